// File: rtl/axi_stream_traffic_checker.sv
// AXI-stream sink: paces its own ready, checks each accepted beat against a
// preloaded expected memory, and reports counts plus the first mismatch.
module axi_stream_traffic_checker #(
  parameter int    DATA_WIDTH     = 40,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    EXPECTED_BEATS = 1024,
  parameter int    READY_PERIOD   = 1,
  parameter string EXPECTED_FILE  = "expected.dat"
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] stream_data,
  input  logic                  stream_valid,
  output logic                  stream_ready,
  output logic [ADDR_WIDTH:0]   beat_count,
  output logic [15:0]           error_count,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] first_error_address,
  output logic [DATA_WIDTH-1:0] first_error_data,
  output logic                  done
);

  localparam int PW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(EXPECTED_BEATS - 1);
  localparam logic [PW-1:0]         LAST_PHASE  = PW'(READY_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, next_state;
  logic [PW-1:0]           phase, next_phase;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    accept, last_accept;

  logic                    cmp_valid, cmp_last;
  logic [DATA_WIDTH-1:0]   cmp_data, cmp_expected;
  logic [ADDR_WIDTH-1:0]   cmp_address;

  logic [DATA_WIDTH-1:0]   expected_mem [2**ADDR_WIDTH];

  // stream_ready is only ever high in RUN, so no state qualifier is needed.
  assign accept      = stream_valid & stream_ready;
  assign last_accept = accept && (address == LAST_ADDR);

  always_comb begin
    next_state = state;
    next_phase = phase;
    case (state)
      IDLE: if (enable) begin
        next_state = RUN;
        next_phase = '0;
      end
      RUN: begin
        if (last_accept)  next_state = DONE;
        else if (!enable) next_state = IDLE;
        else              next_phase = (phase == LAST_PHASE) ? '0 : phase + PW'(1);
      end
      DONE: if (!enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Expected-data read has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (accept) cmp_expected <= expected_mem[address];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= IDLE;
      phase               <= '0;
      address             <= '0;
      stream_ready        <= 1'b0;
      cmp_valid           <= 1'b0;
      cmp_last            <= 1'b0;
      cmp_data            <= '0;
      cmp_address         <= '0;
      beat_count          <= '0;
      error_count         <= '0;
      error               <= 1'b0;
      first_error_address <= '0;
      first_error_data    <= '0;
      done                <= 1'b0;
    end else begin
      state        <= next_state;
      phase        <= next_phase;
      stream_ready <= (next_state == RUN) && (next_phase == '0);
      cmp_valid    <= accept;

      if (accept) begin
        cmp_data    <= stream_data;
        cmp_address <= address;
        cmp_last    <= last_accept;
        address     <= address + ADDR_WIDTH'(1);
      end

      // A compare in flight lands even if the FSM has already left RUN.
      if (cmp_valid) begin
        beat_count <= beat_count + (ADDR_WIDTH+1)'(1);
        if (cmp_data != cmp_expected) begin
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          if (!error) begin
            first_error_address <= cmp_address;
            first_error_data    <= cmp_data;
          end
          error <= 1'b1;
        end
        if (cmp_last) done <= 1'b1;
      end

      if (state == IDLE && enable) begin
        address             <= '0;
        beat_count          <= '0;
        error_count         <= '0;
        error               <= 1'b0;
        first_error_address <= '0;
        first_error_data    <= '0;
        done                <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_traffic_checker.sv
// Bench for axi_stream_traffic_checker: two instances (always-ready full-depth
// run, and a 1-in-3 ready pacing short run) checked against a cycle model.
module tb_axi_stream_traffic_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en1 = 1'b0, v1 = 1'b0, en3 = 1'b0, v3 = 1'b0;
  logic [39:0] d1 = '0, d3 = '0;

  logic        ready1, error1, done1, ready3, error3, done3;
  logic [10:0] beat1, beat3;
  logic [15:0] errc1, errc3;
  logic [9:0]  fea1, fea3;
  logic [39:0] fed1, fed3;

  int npass = 0, ntot = 0;
  bit chk_on = 1'b0;
  bit junk = 1'b0;
  int corrupt_idx = -1;

  always #5 clock = ~clock;

  axi_stream_traffic_checker #(.DATA_WIDTH(40), .ADDR_WIDTH(10), .EXPECTED_BEATS(1024),
    .READY_PERIOD(1), .EXPECTED_FILE("")) dut1 (
    .clock(clock), .reset(reset), .enable(en1), .stream_data(d1), .stream_valid(v1),
    .stream_ready(ready1), .beat_count(beat1), .error_count(errc1), .error(error1),
    .first_error_address(fea1), .first_error_data(fed1), .done(done1));

  axi_stream_traffic_checker #(.DATA_WIDTH(40), .ADDR_WIDTH(10), .EXPECTED_BEATS(8),
    .READY_PERIOD(3), .EXPECTED_FILE("")) dut3 (
    .clock(clock), .reset(reset), .enable(en3), .stream_data(d3), .stream_valid(v3),
    .stream_ready(ready3), .beat_count(beat3), .error_count(errc3), .error(error3),
    .first_error_address(fea3), .first_error_data(fed3), .done(done3));

  // Model: run state, cycles since run start, accepted count, one pending compare.
  typedef struct {
    int mode; int cyc; int acc; bit ready;
    int beats; int errs; bit err; int fea; logic [39:0] fed; bit done;
    bit pend; logic [39:0] pdata; int pidx; bit plast;
  } ms_t;

  ms_t m1, m3;

  function automatic ms_t step(ms_t s, bit rst, bit en, bit vld, logic [39:0] d, int per, int n);
    ms_t r;
    bit  acc;
    r = s;
    if (!rst) begin
      r = '{default: 0};
      return r;
    end
    if (s.pend) begin
      r.beats++;
      if (s.pdata !== 40'(s.pidx)) begin
        if (r.errs < 65535) r.errs++;
        if (!s.err) begin r.fea = s.pidx; r.fed = s.pdata; end
        r.err = 1'b1;
      end
      if (s.plast) r.done = 1'b1;
    end
    acc = s.ready && vld;
    r.pend = acc;
    if (acc) begin
      r.pdata = d; r.pidx = s.acc; r.plast = (s.acc == n - 1); r.acc = s.acc + 1;
    end
    case (s.mode)
      0: if (en) begin
        r.mode = 1; r.cyc = 0; r.acc = 0; r.beats = 0; r.errs = 0;
        r.err = 0; r.fea = 0; r.fed = '0; r.done = 0;
      end
      1: if (acc && s.acc == n - 1) r.mode = 2;
         else if (!en)             r.mode = 0;
         else                      r.cyc = s.cyc + 1;
      default: if (!en) r.mode = 0;
    endcase
    r.ready = (r.mode == 1) && (r.cyc % per == 0);
    return r;
  endfunction

  always @(posedge clock) begin
    m1 = step(m1, reset, en1, v1, d1, 1, 1024);
    m3 = step(m3, reset, en3, v3, d3, 3, 8);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("d1.ready", 64'(ready1), 64'(m1.ready));
      chk("d1.beat_count", 64'(beat1), 64'(m1.beats));
      chk("d1.error_count", 64'(errc1), 64'(m1.errs));
      chk("d1.error", 64'(error1), 64'(m1.err));
      chk("d1.first_error_address", 64'(fea1), 64'(m1.fea));
      chk("d1.first_error_data", 64'(fed1), 64'(m1.fed));
      chk("d1.done", 64'(done1), 64'(m1.done));
      chk("d3.ready", 64'(ready3), 64'(m3.ready));
      chk("d3.beat_count", 64'(beat3), 64'(m3.beats));
      chk("d3.error_count", 64'(errc3), 64'(m3.errs));
      chk("d3.error", 64'(error3), 64'(m3.err));
      chk("d3.done", 64'(done3), 64'(m3.done));
    end
  end

  task automatic upd();
    if (junk) d1 = {$urandom, $urandom}[39:0];
    else      d1 = (m1.acc == corrupt_idx) ? 40'hDEADBEEF00 : 40'(m1.acc);
    d3 = 40'(m3.acc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      upd();
    end
  endtask

  task automatic wait_done1(input string nm);
    int k = 0;
    while (!done1 && k < 1100) begin tick(1); k++; end
    chk(nm, 64'(done1), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dut1.expected_mem[i] = 40'(i);
      dut3.expected_mem[i] = 40'(i);
    end
    tick(3);
    chk_on = 1'b1;
    chk("reset ready", 64'(ready1), 64'd0);
    chk("reset beat_count", 64'(beat1), 64'd0);
    chk("reset done", 64'(done1), 64'd0);
    reset = 1'b1;

    // Full clean run, always ready.
    en1 = 1'b1; v1 = 1'b1;
    tick(1);
    chk("t1 first run cycle ready", 64'(ready1), 64'd1);
    wait_done1("t1 done timeout");
    chk("t1 beat_count", 64'(beat1), 64'd1024);
    chk("t1 error_count", 64'(errc1), 64'd0);
    chk("t1 error", 64'(error1), 64'd0);
    en1 = 1'b0; v1 = 1'b0;
    tick(2);
    chk("t1 results held", 64'(beat1), 64'd1024);

    // Same run with beat 5 corrupted.
    corrupt_idx = 5;
    en1 = 1'b1; v1 = 1'b1;
    tick(1);
    wait_done1("t2 done timeout");
    chk("t2 beat_count", 64'(beat1), 64'd1024);
    chk("t2 error", 64'(error1), 64'd1);
    chk("t2 error_count", 64'(errc1), 64'd1);
    chk("t2 first_error_address", 64'(fea1), 64'd5);
    chk("t2 first_error_data", 64'(fed1), 64'hDEADBEEF00);
    en1 = 1'b0; v1 = 1'b0; corrupt_idx = -1;
    tick(2);

    // Valid gap with junk data, then stop after 100 accepts.
    en1 = 1'b1; v1 = 1'b1;
    tick(20);
    v1 = 1'b0; junk = 1'b1; upd();
    tick(10);
    chk("t3 beat_count frozen", 64'(beat1), 64'd19);
    chk("t3 no false error", 64'(error1), 64'd0);
    junk = 1'b0; upd(); v1 = 1'b1;
    for (int k = 0; k < 200 && m1.acc != 100; k++) tick(1);
    chk("t4 reached 100 accepts", 64'(m1.acc), 64'd100);
    v1 = 1'b0; en1 = 1'b0;
    tick(1);
    chk("t4 ready drops", 64'(ready1), 64'd0);
    tick(1);
    chk("t4 beat_count held", 64'(beat1), 64'd100);
    en1 = 1'b1;
    tick(1);
    chk("t4 re-enable clears beat_count", 64'(beat1), 64'd0);
    chk("t4 re-enable ready", 64'(ready1), 64'd1);

    // Reset with a mismatching compare in flight.
    corrupt_idx = 49; upd(); v1 = 1'b1;
    for (int k = 0; k < 200 && m1.acc != 50; k++) tick(1);
    chk("t5 reached 50 accepts", 64'(m1.acc), 64'd50);
    reset = 1'b0; en1 = 1'b0; v1 = 1'b0;
    tick(1);
    chk("t5 reset beat_count", 64'(beat1), 64'd0);
    chk("t5 reset error", 64'(error1), 64'd0);
    chk("t5 reset ready", 64'(ready1), 64'd0);
    reset = 1'b1; corrupt_idx = -1;
    tick(2);
    chk("t5 error stays clear", 64'(error1), 64'd0);
    chk("t5 idle ready", 64'(ready1), 64'd0);

    // Paced ready 1-in-3, eight beats.
    begin
      int n = 0;
      en3 = 1'b1; v3 = 1'b1;
      tick(1); n++;
      chk("t6 ready phase0", 64'(ready3), 64'd1);
      tick(1); n++;
      chk("t6 ready phase1", 64'(ready3), 64'd0);
      tick(1); n++;
      chk("t6 ready phase2", 64'(ready3), 64'd0);
      tick(1); n++;
      chk("t6 ready phase0 again", 64'(ready3), 64'd1);
      while (!done3 && n < 40) begin tick(1); n++; end
      chk("t6 done", 64'(done3), 64'd1);
      chk("t6 cycles 22..24", 64'(n >= 22 && n <= 24), 64'd1);
      chk("t6 beat_count", 64'(beat3), 64'd8);
      chk("t6 error", 64'(error3), 64'd0);
    end
    en3 = 1'b0; v3 = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
